// File: rtl/kbd_event_ctrl_if.sv
// Decoded key-event channel between kbd_event_ctrl (master) and its consumer (slave).
// The event fields are held stable while evt_valid waits for evt_ready.
interface kbd_event_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_ext,
    output evt_break,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_ext,
    input  evt_break,
    output evt_ready
  );
endinterface

// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code byte stream to key-event decoder: strips E0/F0 prefixes,
// suppresses typematic repeats of the held key, and counts accepted presses.
module kbd_event_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic             kbd_ready,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_overflow,
  output logic             kbd_nextdata_n,
  kbd_event_ctrl_if.master evt,
  output logic             key_down,
  output logic [7:0]       press_cnt,
  output logic             err_ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [7:0] byte_r;
  logic [7:0] evt_code_r;
  logic [7:0] held_code_r;
  logic [7:0] press_cnt_r;
  logic       ext_r;
  logic       brk_r;
  logic       held_ext_r;
  logic       evt_valid_r;
  logic       evt_ext_r;
  logic       evt_break_r;
  logic       key_down_r;
  logic       err_ovf_r;
  logic       nextdata_n_r;
  logic       take_s;
  logic       set_ext_s;
  logic       set_brk_s;
  logic       clr_flags_s;
  logic       load_s;
  logic       done_s;
  logic       repeat_s;

  // Next-state and per-cycle action strobes.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    set_ext_s   = 1'b0;
    set_brk_s   = 1'b0;
    clr_flags_s = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    // A repeated make code of the key already held is typematic and dropped.
    repeat_s    = !brk_r && key_down_r && (byte_r == held_code_r) && (ext_r == held_ext_r);
    case (state_r)
      IDLE: begin
        if (kbd_ready) begin
          take_s      = 1'b1;
          state_nxt_s = POP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      POP: begin
        state_nxt_s = DECODE;
      end
      DECODE: begin
        if (byte_r == 8'hE0) begin
          set_ext_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (byte_r == 8'hF0) begin
          set_brk_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (repeat_s) begin
          clr_flags_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          load_s      = 1'b1;
          state_nxt_s = EMIT;
        end
      end
      EMIT: begin
        if (evt_valid_r && evt.evt_ready) begin
          done_s      = 1'b1;
          clr_flags_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EMIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, event outputs and held-key bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      nextdata_n_r <= 1'b1;
      byte_r       <= 8'h00;
      ext_r        <= 1'b0;
      brk_r        <= 1'b0;
      evt_valid_r  <= 1'b0;
      evt_code_r   <= 8'h00;
      evt_ext_r    <= 1'b0;
      evt_break_r  <= 1'b0;
      held_code_r  <= 8'h00;
      held_ext_r   <= 1'b0;
      key_down_r   <= 1'b0;
      press_cnt_r  <= 8'h00;
      err_ovf_r    <= 1'b0;
    end else begin
      nextdata_n_r <= ~take_s;
      if (take_s) begin
        byte_r <= kbd_data;
      end
      if (clr_flags_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else begin
        if (set_ext_s) ext_r <= 1'b1;
        if (set_brk_s) brk_r <= 1'b1;
      end
      if (load_s) begin
        evt_valid_r <= 1'b1;
        evt_code_r  <= byte_r;
        evt_ext_r   <= ext_r;
        evt_break_r <= brk_r;
      end else if (done_s) begin
        evt_valid_r <= 1'b0;
      end
      if (done_s) begin
        if (!evt_break_r) begin
          held_code_r <= evt_code_r;
          held_ext_r  <= evt_ext_r;
          key_down_r  <= 1'b1;
          press_cnt_r <= press_cnt_r + 8'd1;
        end else if ((evt_code_r == held_code_r) && (evt_ext_r == held_ext_r)) begin
          key_down_r  <= 1'b0;
        end
      end
      if (kbd_overflow) begin
        err_ovf_r <= 1'b1;
      end
    end
  end

  assign kbd_nextdata_n = nextdata_n_r;
  assign evt.evt_valid  = evt_valid_r;
  assign evt.evt_code   = evt_code_r;
  assign evt.evt_ext    = evt_ext_r;
  assign evt.evt_break  = evt_break_r;
  assign key_down       = key_down_r;
  assign press_cnt      = press_cnt_r;
  assign err_ovf        = err_ovf_r;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: a byte-stream decoder model predicts the event list,
// and a per-cycle compare process checks events, held-key state and pop strobes.
module tb_kbd_event_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kbd_ready = 1'b0;
  logic [7:0] kbd_data = 8'h00;
  logic       kbd_overflow = 1'b0;
  logic       kbd_nextdata_n;
  logic       key_down;
  logic [7:0] press_cnt;
  logic       err_ovf;

  kbd_event_ctrl_if evt_if ();

  kbd_event_ctrl dut (
    .clk(clk), .rst(rst), .kbd_ready(kbd_ready), .kbd_data(kbd_data),
    .kbd_overflow(kbd_overflow), .kbd_nextdata_n(kbd_nextdata_n), .evt(evt_if),
    .key_down(key_down), .press_cnt(press_cnt), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  evt_t       expq[$];
  logic [7:0] fifo[$];
  int         errors = 0;
  int         checks = 0;
  int         ready_mode = 1;  // 0: never ready, 1: always ready, 2: random
  int         acc_cnt = 0;
  int         pop_cnt = 0;
  evt_t       last_evt = '0;

  // Stream decoder model: state as seen after all earlier events complete.
  logic       s_ext = 1'b0, s_brk = 1'b0, s_down = 1'b0, s_hext = 1'b0;
  logic [7:0] s_held = 8'h00;
  // Completion model: outputs as they must be after accepted handshakes.
  logic       mk_down = 1'b0, mk_hext = 1'b0, exp_ovf = 1'b0;
  logic [7:0] mk_held = 8'h00, mk_cnt = 8'h00;

  logic [7:0] pool [8] = '{8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'h75, 8'h5A, 8'hF0, 8'h1C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) s_ext = 1'b1;
    else if (b == 8'hF0) s_brk = 1'b1;
    else if (!s_brk && s_down && b == s_held && s_ext == s_hext) begin
      s_ext = 1'b0;
      s_brk = 1'b0;
    end else begin
      expq.push_back({b, s_ext, s_brk});
      if (!s_brk) begin
        s_down = 1'b1; s_held = b; s_hext = s_ext;
      end else if (b == s_held && s_ext == s_hext) begin
        s_down = 1'b0;
      end
      s_ext = 1'b0;
      s_brk = 1'b0;
    end
  endfunction

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    model_byte(b);
    kbd_ready = 1'b1;
    kbd_data  = fifo[0];
  endtask

  task automatic step();
    logic popped;
    @(negedge clk);
    popped = !kbd_nextdata_n;
    @(posedge clk);
    #1;
    if (popped) begin
      chk("pop_nonempty", 32'(fifo.size() > 0), 32'd1);
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    kbd_ready    = (fifo.size() > 0);
    kbd_data     = (fifo.size() > 0) ? fifo[0] : 8'h00;
    kbd_overflow = 1'b0;
    case (ready_mode)
      0:       evt_if.evt_ready = 1'b0;
      1:       evt_if.evt_ready = 1'b1;
      default: evt_if.evt_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    fifo.delete();
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    s_ext = 1'b0; s_brk = 1'b0; s_down = 1'b0; s_hext = 1'b0; s_held = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || expq.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < 2000), 32'd1);
    repeat (4) step();
  endtask

  // Per-cycle compare against the models.
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1, prev_pop_n = 1'b1;
  evt_t prev_evt = '0;
  always @(negedge clk) begin
    logic hs;
    evt_t cur;
    evt_t e;
    cur = {evt_if.evt_code, evt_if.evt_ext, evt_if.evt_break};
    hs  = evt_if.evt_valid && evt_if.evt_ready && !rst;
    chk("key_down", 32'(key_down), 32'(mk_down));
    chk("press_cnt", 32'(press_cnt), 32'(mk_cnt));
    chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    if (prev_rst) begin
      chk("rst_nextdata_n", 32'(kbd_nextdata_n), 32'd1);
      chk("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("rst_evt_fields", 32'(cur), 32'd0);
    end else begin
      if (!kbd_nextdata_n) chk("pop_width", 32'(prev_pop_n), 32'd1);
      if (prev_valid && !prev_hs) begin
        chk("valid_hold", 32'(evt_if.evt_valid), 32'd1);
        chk("evt_stable", 32'(cur), 32'(prev_evt));
      end
      if (prev_hs) chk("valid_drop", 32'(evt_if.evt_valid), 32'd0);
    end
    if (hs) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_evt: got event %0h while none expected", cur);
      end else begin
        e = expq.pop_front();
        chk("evt_fields", 32'(cur), 32'(e));
        if (!e.brk) begin
          mk_down = 1'b1; mk_held = e.code; mk_hext = e.ext; mk_cnt = mk_cnt + 8'd1;
        end else if (e.code == mk_held && e.ext == mk_hext) begin
          mk_down = 1'b0;
        end
        acc_cnt++;
        last_evt = cur;
      end
    end
    if (kbd_overflow) exp_ovf = 1'b1;
    if (rst) begin
      mk_down = 1'b0; mk_hext = 1'b0; mk_held = 8'h00; mk_cnt = 8'h00; exp_ovf = 1'b0;
    end
    if (!kbd_nextdata_n) pop_cnt++;
    prev_valid = evt_if.evt_valid && !rst;
    prev_hs    = hs;
    prev_rst   = rst;
    prev_pop_n = kbd_nextdata_n;
    prev_evt   = cur;
  end

  initial begin
    int base;
    int p0;
    evt_if.evt_ready = 1'b1;
    do_reset();

    // Minimum latency: byte visible in IDLE -> evt_valid on the third edge.
    push(8'h1C);
    step(); step();
    chk("latency_2", 32'(evt_if.evt_valid), 32'd0);
    step();
    chk("latency_3", 32'(evt_if.evt_valid), 32'd1);
    drain();

    // Press/release pairs of two keys.
    do_reset();
    base = acc_cnt;
    foreach (pool[i]) begin end
    push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1B); push(8'hF0); push(8'h1B);
    drain();
    chk("seq1_events", 32'(acc_cnt - base), 32'd4);
    chk("seq1_press_cnt", 32'(press_cnt), 32'h02);
    chk("seq1_key_down", 32'(key_down), 32'd0);

    // Extended press and extended release.
    do_reset();
    base = acc_cnt;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("seq2_events", 32'(acc_cnt - base), 32'd2);
    chk("seq2_last_evt", 32'(last_evt), 32'({8'h75, 1'b1, 1'b1}));

    // Typematic repeats are swallowed.
    do_reset();
    base = acc_cnt;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    chk("seq3_events", 32'(acc_cnt - base), 32'd2);
    chk("seq3_press_cnt", 32'(press_cnt), 32'h01);
    chk("seq3_key_down", 32'(key_down), 32'd0);

    // Backpressure: held event, no further pops.
    do_reset();
    ready_mode = 0;
    evt_if.evt_ready = 1'b0;
    base = acc_cnt;
    p0 = pop_cnt;
    push(8'h2A); push(8'h2B); push(8'h2C);
    repeat (20) step();
    chk("bp_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("bp_code", 32'(evt_if.evt_code), 32'h2A);
    chk("bp_pops", 32'(pop_cnt - p0), 32'd1);
    ready_mode = 1;
    drain();
    chk("bp_events", 32'(acc_cnt - base), 32'd3);
    chk("bp_last_code", 32'(last_evt.code), 32'h2C);

    // Sticky overflow flag.
    kbd_overflow = 1'b1;
    step();
    chk("ovf_set", 32'(err_ovf), 32'd1);
    repeat (5) step();
    chk("ovf_sticky", 32'(err_ovf), 32'd1);

    // Reset while an event is pending drops it.
    ready_mode = 0;
    evt_if.evt_ready = 1'b0;
    push(8'h3C);
    repeat (4) step();
    chk("emit_before_rst", 32'(evt_if.evt_valid), 32'd1);
    do_reset();
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_err_ovf", 32'(err_ovf), 32'd0);
    chk("rst_key_down", 32'(key_down), 32'd0);
    ready_mode = 1;
    drain();

    // press_cnt wraps after 256 presses.
    do_reset();
    base = acc_cnt;
    for (int i = 0; i < 257; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h1B);
      drain();
    end
    chk("wrap_events", 32'(acc_cnt - base), 32'd257);
    chk("wrap_press_cnt", 32'(press_cnt), 32'h01);

    // Random byte stream with random consumer stalls and overflow pulses.
    do_reset();
    ready_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0 && fifo.size() < 6) push(pool[$urandom_range(0, 7)]);
      if ($urandom_range(0, 199) == 0) kbd_overflow = 1'b1;
      step();
    end
    ready_mode = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 kbd_ready  input  1  receiver FIFO non-empty, from ps2_keyboard ready.
REQ-004 kbd_data  input  8  receiver FIFO head byte, from ps2_keyboard data.
REQ-005 kbd_overflow  input  1  receiver FIFO overflow flag.
REQ-006 kbd_nextdata_n  output  1  registered pop strobe to the receiver; active low, one cycle per byte.
REQ-007 evt_valid  output  1  decoded key event available.
REQ-008 evt_ready  input  1  consumer accepts the event.
REQ-009 evt_code  output  8  scan code of the event, prefixes stripped.
REQ-010 evt_ext  output  1  event was preceded by an E0 prefix.
REQ-011 evt_break  output  1  1 = release (F0 seen), 0 = press.
REQ-012 key_down  output  1  the last pressed key is still held.
REQ-013 press_cnt  output  8  count of accepted press events.
REQ-014 err_ovf  output  1  sticky: kbd_overflow was seen high.

Function
REQ-015 FSM states: IDLE, POP, DECODE, EMIT.
REQ-016 IDLE, kbd_ready=1: latch kbd_data into byte_q, drive kbd_nextdata_n=0 next cycle, go to POP; otherwise stay in IDLE with kbd_nextdata_n=1.
REQ-017 POP: kbd_nextdata_n returns to 1; go to DECODE unconditionally, giving the receiver one settle cycle.
REQ-018 kbd_nextdata_n is low for exactly one cycle per consumed byte and never in two consecutive cycles.
REQ-019 DECODE, byte_q=E0: set ext_f, go to IDLE; no event.
REQ-020 DECODE, byte_q=F0: set brk_f, go to IDLE; no event.
REQ-021 DECODE, other byte: load evt_code=byte_q, evt_ext=ext_f, evt_break=brk_f, go to EMIT.
REQ-022 Typematic suppression: in DECODE, a press (brk_f=0) with key_down=1, byte_q=held_code and ext_f=held_ext is discarded; clear ext_f/brk_f and go to IDLE.
REQ-023 EMIT: evt_valid=1; evt_code/evt_ext/evt_break stay stable until handshake.
REQ-024 Handshake: evt_valid & evt_ready at a clock edge completes the event; go to IDLE and clear ext_f and brk_f; evt_valid drops next cycle.
REQ-025 No new byte is popped while in EMIT; backpressure holds bytes in the receiver FIFO.
REQ-026 On completed press: held_code<=evt_code, held_ext<=evt_ext, key_down<=1, press_cnt<=press_cnt+1 mod 256 (FF wraps to 00).
REQ-027 On completed release matching held_code/held_ext: key_down<=0; a non-matching release leaves key_down unchanged.
REQ-028 Minimum latency: kbd_ready high in IDLE to evt_valid high is 3 cycles (IDLE->POP->DECODE->EMIT).
REQ-029 kbd_overflow high in any cycle sets err_ovf=1 next cycle; err_ovf clears only on rst; decoding is unaffected.
REQ-030 E0 followed by F0 sets both flags; the next code byte yields evt_ext=1, evt_break=1.

Reset
REQ-031 rst=1 at a clock edge forces state=IDLE, kbd_nextdata_n=1, evt_valid=0, evt_code=00, evt_ext=0, evt_break=0, key_down=0, press_cnt=00, err_ovf=0, ext_f=0, brk_f=0, held_code=00, held_ext=0.
REQ-032 rst takes priority over all other inputs in every state, including mid-EMIT and mid-POP; a pending event is dropped.

Verification
REQ-033 Bytes 1C, F0, 1C, 1B, F0, 1B, evt_ready=1 -> four events: (1C,brk0),(1C,brk1),(1B,brk0),(1B,brk1); press_cnt=02; key_down=0 at end.
REQ-034 Bytes E0, 75, E0, F0, 75 -> events (75,ext1,brk0) and (75,ext1,brk1); no events for prefixes.
REQ-035 Bytes 1C, 1C, 1C, F0, 1C -> exactly two events: press 1C and release 1C; press_cnt=01.
REQ-036 evt_ready=0 for 20 cycles with 3 bytes queued -> evt_valid held, evt_code stable, kbd_nextdata_n stays 1; after evt_ready=1 the remaining bytes decode in order.
REQ-037 kbd_overflow pulsed 1 cycle -> err_ovf=1 from next cycle until rst; rst asserted during EMIT -> evt_valid=0 and all outputs at reset values next cycle.
REQ-038 Check every pop: kbd_nextdata_n low for exactly one cycle, followed by at least one high cycle.
